led_walk_monitor: RTL

- Observes the N_LEDS-wide walking-LED bus produced by the LED shift generators and decodes it back into position, direction and step events.
- Checks the pattern against the legal one-hot walking sequence and flags illegal patterns or skipped positions.
- Sits on the LED output bus, clocked with the generator; used as a self-check block and as a step counter.

---
 rtl/led_walk_monitor.sv | 128 ++++++++++++
 1 files changed

// File: rtl/led_walk_monitor.sv
// Decodes a one-hot walking-LED bus back into position, direction and step events,
// and flags illegal patterns or jumps of more than one position.
module led_walk_monitor #(
    parameter int N_LEDS = 4,
    parameter int POS_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_sample_en,
    input  logic              i_clear,
    input  logic [N_LEDS-1:0] i_leds,
    output logic              o_valid,
    output logic [POS_W-1:0]  o_pos,
    output logic              o_dir,
    output logic              o_step,
    output logic              o_dir_change,
    output logic              o_err,
    output logic [CNT_W-1:0]  o_step_count
);

    typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;

    state_t             state, state_nx;
    logic               any_bit, multi_bit, legal;
    logic [POS_W-1:0]   p, up_pos, dn_pos;
    logic               is_up, is_dn;
    logic               valid_nx, dir_nx, step_nx, dc_nx, err_nx;
    logic [POS_W-1:0]   pos_nx;
    logic [CNT_W-1:0]   cnt_nx;

    // One-hot check and index of the lit LED
    always_comb begin
        any_bit   = 1'b0;
        multi_bit = 1'b0;
        p         = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            if (i_leds[i]) begin
                if (any_bit) multi_bit = 1'b1;
                any_bit = 1'b1;
                p       = POS_W'(i);
            end
        end
        legal = any_bit & ~multi_bit;
    end

    // Neighbour positions of the previous index, with wrap at both ends
    always_comb begin
        up_pos = (o_pos == POS_W'(N_LEDS - 1)) ? '0 : o_pos + POS_W'(1);
        dn_pos = (o_pos == '0) ? POS_W'(N_LEDS - 1) : o_pos - POS_W'(1);
        is_up  = (p == up_pos);
        is_dn  = (p == dn_pos);
    end

    always_comb begin
        state_nx = state;
        valid_nx = o_valid;
        pos_nx   = o_pos;
        dir_nx   = o_dir;
        step_nx  = 1'b0;
        dc_nx    = 1'b0;
        err_nx   = 1'b0;
        if (i_sample_en) begin
            if (!legal) begin
                err_nx   = 1'b1;
                valid_nx = 1'b0;
                state_nx = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        valid_nx = 1'b1;
                        pos_nx   = p;
                        state_nx = ACQ;
                    end
                    ACQ, TRACK: begin
                        if (p == o_pos) begin
                            valid_nx = 1'b1;
                        end else if (is_up || is_dn) begin
                            step_nx  = 1'b1;
                            pos_nx   = p;
                            dir_nx   = is_up;
                            // Reversal only counts once a direction is established
                            dc_nx    = (state == TRACK) && (is_up != o_dir);
                            state_nx = TRACK;
                        end else begin
                            err_nx   = 1'b1;
                            valid_nx = 1'b1;
                            pos_nx   = p;
                            state_nx = ACQ;
                        end
                    end
                    default: state_nx = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        cnt_nx = o_step_count;
        if (i_clear)
            cnt_nx = '0;
        else if (step_nx && (o_step_count != {CNT_W{1'b1}}))
            cnt_nx = o_step_count + CNT_W'(1);
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state        <= IDLE;
            o_valid      <= 1'b0;
            o_pos        <= '0;
            o_dir        <= 1'b0;
            o_step       <= 1'b0;
            o_dir_change <= 1'b0;
            o_err        <= 1'b0;
            o_step_count <= '0;
        end else begin
            state        <= state_nx;
            o_valid      <= valid_nx;
            o_pos        <= pos_nx;
            o_dir        <= dir_nx;
            o_step       <= step_nx;
            o_dir_change <= dc_nx;
            o_err        <= err_nx;
            o_step_count <= cnt_nx;
        end
    end

endmodule
